// File: rtl/fighter_health_if.sv
// fighter_health_if: control and status bundle between player logic and the health tracker
// master drives frame_tick/round_start/hit/damage, slave (the tracker) drives health and round status
interface fighter_health_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int HEALTH_W    = 8,
  parameter int DMG_W       = 5
) ();
  localparam int WIN_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  logic                         i_frame_tick;
  logic                         i_round_start;
  logic [NUM_PLAYERS-1:0]       i_hit;
  logic [NUM_PLAYERS*DMG_W-1:0] i_damage;
  logic [NUM_PLAYERS*HEALTH_W-1:0] o_health;
  logic [NUM_PLAYERS-1:0]       o_ko;
  logic [NUM_PLAYERS-1:0]       o_invuln;
  logic                         o_fighting;
  logic                         o_game_over;
  logic [WIN_W-1:0]             o_winner;
  logic                         o_draw;
  modport master (
    output i_frame_tick, i_round_start, i_hit, i_damage,
    input  o_health, o_ko, o_invuln, o_fighting, o_game_over, o_winner, o_draw
  );
  modport slave (
    input  i_frame_tick, i_round_start, i_hit, i_damage,
    output o_health, o_ko, o_invuln, o_fighting, o_game_over, o_winner, o_draw
  );
endinterface

// File: rtl/fighter_health.sv
// fighter_health: per-fighter health, invulnerability, regen and round/KO tracking
// i_clk, i_rst_n (async active-low); bus.slave carries frame_tick, round_start, hit, damage in
// and health, ko, invuln, fighting, game_over, winner, draw out
module fighter_health #(
  parameter int NUM_PLAYERS  = 2,
  parameter int HEALTH_W     = 8,
  parameter int MAX_HEALTH   = 200,
  parameter int DMG_W        = 5,
  parameter int IFRAMES      = 30,
  parameter int REGEN_PERIOD = 0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  fighter_health_if.slave bus
);
  localparam int WIN_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int AW    = $clog2(NUM_PLAYERS + 1);
  localparam int IF_W  = (IFRAMES > 0) ? $clog2(IFRAMES + 1) : 1;
  localparam int RG_W  = (REGEN_PERIOD > 1) ? $clog2(REGEN_PERIOD) : 1;
  localparam int SW    = (HEALTH_W > DMG_W) ? HEALTH_W : DMG_W;
  localparam logic [HEALTH_W-1:0] MAX_H   = HEALTH_W'(MAX_HEALTH);
  localparam logic [IF_W-1:0]     IF_LOAD = IF_W'(IFRAMES);
  localparam logic [RG_W-1:0]     RG_LAST = RG_W'((REGEN_PERIOD > 0) ? REGEN_PERIOD - 1 : 0);

  typedef enum logic [1:0] {IDLE, FIGHT, OVER} state_t;

  state_t                 r_state, w_state;
  logic [HEALTH_W-1:0]    r_health [NUM_PLAYERS];
  logic [HEALTH_W-1:0]    w_health [NUM_PLAYERS];
  logic [IF_W-1:0]        r_ifr [NUM_PLAYERS];
  logic [IF_W-1:0]        w_ifr [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] r_ko, w_ko;
  logic [RG_W-1:0]        r_rc, w_rc;
  logic [WIN_W-1:0]       r_winner, w_winner, w_last;
  logic                   r_draw, w_draw, w_wrap, w_acc;
  logic [AW-1:0]          w_alive;
  logic [SW-1:0]          w_dmg;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state;

  always_comb begin
    w_state  = r_state;
    w_health = r_health;
    w_ifr    = r_ifr;
    w_ko     = r_ko;
    w_rc     = r_rc;
    w_winner = r_winner;
    w_draw   = r_draw;
    w_last   = '0;
    w_alive  = '0;
    w_acc    = 1'b0;
    w_dmg    = '0;
    w_wrap   = (REGEN_PERIOD > 0) && bus.i_frame_tick && (r_rc == RG_LAST);
    if (bus.i_round_start) begin
      w_state = FIGHT;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        w_health[i] = MAX_H;
        w_ifr[i]    = '0;
      end
      w_ko     = '0;
      w_rc     = '0;
      w_winner = '0;
      w_draw   = 1'b0;
    end else if (r_state == FIGHT) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        w_acc = bus.i_hit[i] && !r_ko[i] && (r_ifr[i] == '0);
        w_dmg = SW'(bus.i_damage[i*DMG_W +: DMG_W]);
        if (w_acc) begin
          w_health[i] = (w_dmg >= SW'(r_health[i])) ? '0 : r_health[i] - HEALTH_W'(w_dmg);
          w_ifr[i]    = IF_LOAD;
        end else begin
          // regen looks at the pre-edge iframe count, so a player whose iframes expire on this tick waits one period
          if (w_wrap && !r_ko[i] && (r_ifr[i] == '0) && (r_health[i] < MAX_H))
            w_health[i] = r_health[i] + HEALTH_W'(1);
          if (bus.i_frame_tick && (r_ifr[i] != '0))
            w_ifr[i] = r_ifr[i] - IF_W'(1);
        end
        if (w_health[i] == '0) w_ko[i] = 1'b1;
        if (!w_ko[i]) begin
          w_alive = w_alive + AW'(1);
          w_last  = WIN_W'(i);
        end
      end
      if ((REGEN_PERIOD > 0) && bus.i_frame_tick) w_rc = w_wrap ? '0 : r_rc + RG_W'(1);
      if (w_alive <= AW'(1)) begin
        w_state  = OVER;
        w_winner = (w_alive == AW'(1)) ? w_last : '0;
        w_draw   = (w_alive == '0);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        r_health[i] <= MAX_H;
        r_ifr[i]    <= '0;
      end
      r_ko     <= '0;
      r_rc     <= '0;
      r_winner <= '0;
      r_draw   <= 1'b0;
    end else begin
      r_health <= w_health;
      r_ifr    <= w_ifr;
      r_ko     <= w_ko;
      r_rc     <= w_rc;
      r_winner <= w_winner;
      r_draw   <= w_draw;
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_out
    assign bus.o_health[g*HEALTH_W +: HEALTH_W] = r_health[g];
    assign bus.o_invuln[g] = (r_ifr[g] != '0);
  end
  assign bus.o_ko        = r_ko;
  assign bus.o_fighting  = (r_state == FIGHT);
  assign bus.o_game_over = (r_state == OVER);
  assign bus.o_winner    = r_winner;
  assign bus.o_draw      = r_draw;
endmodule

// File: tb/tb_fighter_health.sv
// tb_fighter_health: directed round scenarios plus random play against a behavioural model
module tb_fighter_health;
  localparam int N = 2, HW = 8, MAXH = 200, DW = 5, IFR = 3, RP = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  int mh [N];
  int mi [N];
  int mko [N];
  int mrc, mst, mwin, mdraw;

  fighter_health_if #(.NUM_PLAYERS(N), .HEALTH_W(HW), .DMG_W(DW)) bus ();
  fighter_health #(
    .NUM_PLAYERS(N), .HEALTH_W(HW), .MAX_HEALTH(MAXH), .DMG_W(DW), .IFRAMES(IFR), .REGEN_PERIOD(RP)
  ) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < N; i++) begin mh[i] = MAXH; mi[i] = 0; mko[i] = 0; end
    mrc = 0; mst = 0; mwin = 0; mdraw = 0;
  endtask

  // state: 0 idle, 1 fight, 2 over
  task automatic mstep();
    int alive, last, d;
    bit wrap;
    if (bus.i_round_start) begin
      mreset();
      mst = 1;
    end else if (mst == 1) begin
      wrap = bus.i_frame_tick && (mrc == RP - 1);
      alive = 0; last = 0;
      for (int i = 0; i < N; i++) begin
        d = int'(bus.i_damage[i*DW +: DW]);
        if (bus.i_hit[i] && mko[i] == 0 && mi[i] == 0) begin
          mh[i] = (mh[i] > d) ? mh[i] - d : 0;
          mi[i] = IFR;
        end else begin
          if (wrap && mko[i] == 0 && mi[i] == 0 && mh[i] < MAXH) mh[i]++;
          if (bus.i_frame_tick && mi[i] > 0) mi[i]--;
        end
        if (mh[i] == 0) mko[i] = 1;
        if (mko[i] == 0) begin alive++; last = i; end
      end
      if (bus.i_frame_tick) mrc = (mrc + 1) % RP;
      if (alive <= 1) begin
        mst = 2;
        mwin = (alive == 1) ? last : 0;
        mdraw = (alive == 0) ? 1 : 0;
      end
    end
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) mreset();
      else mstep();
    end
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("health%0d", i), 32'(bus.o_health[i*HW +: HW]), mh[i]);
      chk($sformatf("ko%0d", i), 32'(bus.o_ko[i]), mko[i]);
      chk($sformatf("invuln%0d", i), 32'(bus.o_invuln[i]), 32'(mi[i] != 0));
    end
    chk("fighting", 32'(bus.o_fighting), 32'(mst == 1));
    chk("game_over", 32'(bus.o_game_over), 32'(mst == 2));
    chk("winner", 32'(bus.o_winner), mwin);
    chk("draw", 32'(bus.o_draw), mdraw);
  end

  task automatic step(input logic ft, input logic rs, input logic [1:0] h, input int d0, input int d1);
    bus.i_frame_tick = ft;
    bus.i_round_start = rs;
    bus.i_hit = h;
    bus.i_damage = {DW'(d1), DW'(d0)};
    @(negedge clk);
    bus.i_frame_tick = 1'b0;
    bus.i_round_start = 1'b0;
    bus.i_hit = '0;
    bus.i_damage = '0;
  endtask

  task automatic ticks(input int n);
    repeat (n) step(1'b1, 1'b0, 2'b00, 0, 0);
  endtask

  function automatic int hp(input int i);
    return int'(bus.o_health[i*HW +: HW]);
  endfunction

  initial begin
    bus.i_frame_tick = 1'b0;
    bus.i_round_start = 1'b0;
    bus.i_hit = '0;
    bus.i_damage = '0;
    repeat (3) @(negedge clk);
    chk("rst_health0", hp(0), 200);
    chk("rst_health1", hp(1), 200);
    chk("rst_fighting", 32'(bus.o_fighting), 0);
    chk("rst_game_over", 32'(bus.o_game_over), 0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 2'b01, 10, 0);
    chk("idle_hit_ignored", hp(0), 200);
    step(1'b0, 1'b1, 2'b00, 0, 0);
    chk("start_fighting", 32'(bus.o_fighting), 1);
    chk("start_ko", 32'(bus.o_ko), 0);
    // iframes
    step(1'b0, 1'b0, 2'b10, 0, 20);
    chk("hit1_health", hp(1), 180);
    chk("hit1_invuln", 32'(bus.o_invuln[1]), 1);
    step(1'b0, 1'b0, 2'b10, 0, 20);
    ticks(1);
    step(1'b0, 1'b0, 2'b10, 0, 20);
    chk("iframe_reject", hp(1), 180);
    ticks(2);
    chk("iframe_expired", 32'(bus.o_invuln[1]), 0);
    step(1'b0, 1'b0, 2'b10, 0, 20);
    chk("rehit_health", hp(1), 160);
    // saturation and KO
    step(1'b0, 1'b1, 2'b00, 0, 0);
    repeat (6) begin step(1'b0, 1'b0, 2'b01, 31, 0); ticks(3); end
    step(1'b0, 1'b0, 2'b01, 9, 0);
    ticks(3);
    chk("pre_ko_health0", hp(0), 5);
    step(1'b0, 1'b0, 2'b01, 31, 0);
    chk("sat_health0", hp(0), 0);
    chk("ko0", 32'(bus.o_ko), 1);
    chk("ko_game_over", 32'(bus.o_game_over), 1);
    chk("ko_winner", 32'(bus.o_winner), 1);
    chk("ko_draw", 32'(bus.o_draw), 0);
    step(1'b0, 1'b0, 2'b10, 0, 5);
    chk("over_hit_ignored", hp(1), 200);
    // simultaneous KO
    step(1'b0, 1'b1, 2'b00, 0, 0);
    repeat (6) begin step(1'b0, 1'b0, 2'b11, 31, 31); ticks(3); end
    step(1'b0, 1'b0, 2'b11, 11, 11);
    ticks(3);
    chk("both_at_3", hp(0) + hp(1), 6);
    step(1'b0, 1'b0, 2'b11, 3, 3);
    chk("dko_ko", 32'(bus.o_ko), 3);
    chk("dko_draw", 32'(bus.o_draw), 1);
    chk("dko_winner", 32'(bus.o_winner), 0);
    chk("dko_game_over", 32'(bus.o_game_over), 1);
    // regen
    step(1'b0, 1'b1, 2'b00, 0, 0);
    repeat (3) begin step(1'b0, 1'b0, 2'b01, 31, 0); ticks(3); end
    step(1'b0, 1'b0, 2'b01, 7, 0);
    ticks(3);
    chk("regen_base", hp(0), 100);
    ticks(3);
    chk("regen_not_yet", hp(0), 100);
    ticks(1);
    chk("regen_step", hp(0), 101);
    chk("regen_cap", hp(1), 200);
    ticks(3);
    step(1'b1, 1'b0, 2'b01, 0, 0);
    chk("regen_suppressed", hp(0), 101);
    chk("zero_dmg_invuln", 32'(bus.o_invuln[0]), 1);
    // round_start beats hit
    step(1'b0, 1'b1, 2'b11, 31, 31);
    chk("rs_hit_health", hp(0) + hp(1), 400);
    chk("rs_hit_invuln", 32'(bus.o_invuln), 0);
    // async reset mid-round
    step(1'b0, 1'b0, 2'b01, 20, 0);
    chk("pre_reset_health", hp(0), 180);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_health", hp(0), 200);
    chk("async_rst_fighting", 32'(bus.o_fighting), 0);
    chk("async_rst_invuln", 32'(bus.o_invuln), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // random play
    for (int c = 0; c < 4000; c++) begin
      bus.i_frame_tick = ($urandom_range(0, 2) == 0);
      bus.i_round_start = ($urandom_range(0, 59) == 0);
      bus.i_hit = 2'($urandom_range(0, 3) & $urandom_range(0, 3));
      bus.i_damage = (N*DW)'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
      @(negedge clk);
    end
    bus.i_frame_tick = 1'b0;
    bus.i_round_start = 1'b0;
    bus.i_hit = '0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fighter_health.md
# fighter_health

Parametrised, single-clock health/KO tracker for N fighters, succeeding the fixed per-player health bar. Accepts per-player hit strobes with damage amounts, enforces invulnerability frames, optionally regenerates health, and runs a round state machine (idle/fight/over) that reports KO flags and the winner. Sits between the hit-detection/player-control logic and the colour mapper, advanced by a one-cycle frame strobe derived from VGA vsync.

## Interface
- NUM_PLAYERS, 2, number of fighters (2..8)
- HEALTH_W, 8, health value width
- MAX_HEALTH, 200, full-health value (must be < 2^HEALTH_W, > 0)
- DMG_W, 5, per-hit damage width
- IFRAMES, 30, invulnerability length in frames after an accepted hit (0 = none)
- REGEN_PERIOD, 0, frames between +1 regen steps (0 = regen disabled)

- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per video frame
- round_start  in  1  one-cycle pulse: refill all health, enter FIGHT
- hit  in  NUM_PLAYERS  per-player hit request, bit i = player i
- damage  in  NUM_PLAYERS*DMG_W  packed damage, player i at [i*DMG_W +: DMG_W]
- health  out  NUM_PLAYERS*HEALTH_W  packed current health
- ko  out  NUM_PLAYERS  player health is 0
- invuln  out  NUM_PLAYERS  player invulnerability counter non-zero
- fighting  out  1  state == FIGHT
- game_over  out  1  state == OVER
- winner  out  max(1,$clog2(NUM_PLAYERS))  index of sole survivor, valid when game_over & ~draw
- draw  out  1  round ended with no survivor

## Operation
- States: IDLE, FIGHT, OVER. Reset -> IDLE.
- round_start (any state): all health = MAX_HEALTH, ko = 0, iframe counters = 0, regen counter = 0, winner = 0, draw = 0, state -> FIGHT. round_start overrides every other event that cycle.
- IDLE and OVER: hits, regen, and iframe decrement are ignored; all outputs hold.
- FIGHT, hit acceptance: hit[i] accepted iff ~ko[i] and iframe counter[i] == 0 (value before this edge). Accepted: health[i] = max(health[i] - damage[i], 0), saturating, no wrap; iframe counter[i] loaded with IFRAMES. damage = 0 is still accepted and still loads IFRAMES. Rejected hits are dropped, not queued.
- Iframes: each non-zero counter decrements by 1 on frame_tick. An accepted hit on the same edge loads IFRAMES (load wins over decrement).
- KO: ko[i] set on the edge where health[i] becomes 0; clears only on round_start.
- Round end: if, after this edge's updates, the number of players with ko = 0 is <= 1, state -> OVER on the same edge. One survivor: winner = its index, draw = 0. Zero survivors (simultaneous KOs): draw = 1, winner = 0.
- Regen (REGEN_PERIOD > 0, FIGHT only): a frame counter increments on frame_tick and wraps to 0 at REGEN_PERIOD-1; on the wrapping tick each player with ~ko, invuln = 0, and health < MAX_HEALTH gains 1 (never exceeds MAX_HEALTH). An accepted hit on player i suppresses regen for i on that edge; the regen counter advances regardless.
- Players are independent; simultaneous hits on different players are all processed in the same cycle.

## Timing
- All outputs registered. Reset values: health = MAX_HEALTH per player, ko = 0, invuln = 0, fighting = 0, game_over = 0, winner = 0, draw = 0.
- Latency: hit or round_start on edge k -> health/ko/invuln/state visible after edge k (1 cycle).
- invuln rises the cycle after an accepted hit (IFRAMES > 0) and falls after the IFRAMES-th subsequent frame_tick.
- Reset_n asserted mid-round: immediate asynchronous return to the reset values; no round in progress survives.
- hit is level-sampled each cycle. Because of iframes, a hit held high is re-accepted only after invuln falls. With IFRAMES = 0, a held hit is applied every cycle.

## Test plan
- Reset then round_start: health = {200,200}, fighting = 1, ko = 0; hit[0] with damage 10 before round_start -> no change (IDLE).
- FIGHT, IFRAMES=3: hit[1] dmg 20 -> health[1] = 180, invuln[1] = 1; repeat hit dmg 20 before 3 frame_ticks -> ignored; after 3rd tick invuln[1] = 0, hit dmg 20 -> 160.
- Saturation and KO: health[0] = 5, hit dmg 31 -> health[0] = 0, ko[0] = 1, game_over = 1, winner = 1, draw = 0 on the same edge; further hits ignored.
- Simultaneous KO: both health = 3, hit = 2'b11 dmg 3 each -> both ko, game_over = 1, draw = 1.
- Regen, REGEN_PERIOD=4: health[0] = 100, no hits -> 101 after the 4th frame_tick; a hit with dmg 0 on the wrapping tick -> stays 100. Health never exceeds 200.
- round_start and hit on the same cycle; Reset_n pulsed mid-FIGHT -> round_start yields full health with no damage applied; Reset_n asynchronously restores reset values with fighting = 0.
